icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_BITS, default 6, sets the number of cache lines to 2^INDEX_BITS, with one 32-bit word per line.
REQ-002 Parameter TAG_BITS is derived as 30-INDEX_BITS.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 rdy  input  1  global ready; low freezes all state and outputs.
REQ-007 IC_addr_sgn  input  1  fetch request strobe from ifetch.
REQ-008 IC_addr  input  32  fetch byte address; bits [1:0] are ignored.
REQ-009 rollback  input  1  pipeline flush from the ROB.
REQ-010 IC_ins_sgn  output  1  one-cycle pulse marking IC_ins valid.
REQ-011 IC_ins  output  32  fetched instruction word.
REQ-012 mem_req  output  1  level request to the memory controller; held until mem_valid.
REQ-013 mem_addr  output  32  word-aligned miss address; stable while mem_req is high.
REQ-014 mem_valid  input  1  one-cycle pulse; mem_data is valid in that cycle.
REQ-015 mem_data  input  32  returned word.

Function
REQ-016 Line storage: valid bit, tag = addr[31:INDEX_BITS+2], data word; index = addr[INDEX_BITS+1:2].
REQ-017 FSM states: IDLE, MISS_WAIT, DISCARD; reset state is IDLE.
REQ-018 IDLE samples IC_addr_sgn; a new request is accepted only in IDLE.
REQ-019 Hit in IDLE: on the next rising edge, IC_ins_sgn=1 and IC_ins=line data; state stays IDLE (latency 1 cycle).
REQ-020 Miss in IDLE: on the next edge, mem_req=1, mem_addr={IC_addr[31:2],2'b00}, and the index and tag are latched; state goes to MISS_WAIT.
REQ-021 MISS_WAIT with mem_valid=1: write the line (valid=1, latched tag, mem_data), drive mem_req=0, IC_ins_sgn=1 and IC_ins=mem_data on the same edge, then return to IDLE.
REQ-022 IC_ins_sgn is a single-cycle pulse; it is 0 in every cycle not named in REQ-019 or REQ-021.
REQ-023 IC_ins holds its last value when IC_ins_sgn=0.
REQ-024 rollback=1 in IDLE suppresses any hit or miss response for a simultaneous IC_addr_sgn; no state change.
REQ-025 rollback=1 in MISS_WAIT without mem_valid moves to DISCARD; mem_req stays 1 and mem_addr is unchanged.
REQ-026 rollback=1 in MISS_WAIT with mem_valid=1 in the same cycle fills the line, produces no IC_ins_sgn, and goes to IDLE.
REQ-027 DISCARD with mem_valid=1 fills the line, drives mem_req=0, produces no IC_ins_sgn, and goes to IDLE.
REQ-028 IC_addr_sgn outside IDLE is ignored and not queued.
REQ-029 rdy=0 holds all registers; an IC_ins_sgn or mem_req level is held as-is, and a mem_valid arriving during rdy=0 is the memory controller's responsibility not to issue.
REQ-030 Lines are never invalidated except by reset.
REQ-031 The block is read-only; it has no write path.

Reset
REQ-032 rst low asynchronously clears all valid bits and forces state=IDLE, IC_ins_sgn=0, IC_ins=0, mem_req=0, mem_addr=0.
REQ-033 Reset mid-miss abandons the request; an mem_valid arriving after reset release in IDLE is ignored.
REQ-034 The data and tag arrays need not be cleared.

Verification
REQ-035 Cold miss: IC_addr_sgn with IC_addr=0x0000_0000 -> mem_req=1, mem_addr=0x0; mem_valid with data 0x0000_0093 three cycles later -> IC_ins_sgn=1, IC_ins=0x0000_0093 on the same edge, mem_req=0.
REQ-036 Hit: repeat the fetch of 0x0 -> IC_ins_sgn one cycle after the request, IC_ins=0x0000_0093, mem_req stays 0.
REQ-037 Conflict: 0x100 (index 0, tag 1) misses; fill with 0xDEAD_BEEF; then 0x0 misses again -> two separate memory requests.
REQ-038 Rollback mid-miss: request 0x40 miss, rollback the next cycle, mem_valid later with 0x1234_5678 -> no IC_ins_sgn; a subsequent fetch of 0x40 hits with 0x1234_5678.
REQ-039 rdy gating: drop rdy for 4 cycles during MISS_WAIT -> mem_req and mem_addr are held, no spurious IC_ins_sgn, and the miss completes normally after rdy returns.
REQ-040 Async reset: assert rst low between clock edges in MISS_WAIT -> mem_req=0 immediately, and the next fetch of a previously cached address misses.

Source files
------------

// File: rtl/icache_if.sv
// icache_if -- fetch-side and memory-side bus of the instruction cache.
//
// Signals:
//   IC_addr_sgn / IC_addr / rollback : fetch request and pipeline flush (to cache)
//   IC_ins_sgn / IC_ins              : instruction return pulse and word (from cache)
//   mem_req / mem_addr               : line-miss request to memory (from cache)
//   mem_valid / mem_data             : memory return pulse and word (to cache)
//
// Modports:
//   slave  : the cache itself
//   master : its environment (instruction fetch plus memory controller)
interface icache_if;
  logic        IC_addr_sgn;
  logic [31:0] IC_addr;
  logic        rollback;
  logic        IC_ins_sgn;
  logic [31:0] IC_ins;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;

  modport slave (
    input  IC_addr_sgn, IC_addr, rollback, mem_valid, mem_data,
    output IC_ins_sgn, IC_ins, mem_req, mem_addr
  );

  modport master (
    output IC_addr_sgn, IC_addr, rollback, mem_valid, mem_data,
    input  IC_ins_sgn, IC_ins, mem_req, mem_addr
  );
endinterface

// File: rtl/icache.sv
// icache -- direct-mapped, read-only instruction cache with one 32-bit word
// per line and 2^INDEX_BITS lines.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   rdy  : global ready; when low every register holds its value
//   bus  : icache_if.slave (fetch request/response and memory miss port)
//
// A hit answers one cycle after the request. A miss raises mem_req with the
// word-aligned address and waits for mem_valid; the returned word is written
// into the line and forwarded in the same edge. A rollback during a miss
// still lets the fill complete (the line stays useful) but suppresses the
// response to the flushed fetch.
module icache #(
  parameter int  INDEX_BITS = 6,
  localparam int TAG_BITS   = 30 - INDEX_BITS,
  localparam int LINES      = 1 << INDEX_BITS
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  icache_if.slave  bus
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] MISS_WAIT = 2'd1;
  localparam logic [1:0] DISCARD   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic                ins_sgn_q, ins_sgn_d;
  logic [31:0]         ins_q, ins_d;
  logic                mem_req_q, mem_req_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic                fill_en;

  // Tag/data storage carries no reset; only the valid bits are cleared.
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  logic [INDEX_BITS-1:0] req_idx, miss_idx;
  logic [TAG_BITS-1:0]   req_tag, miss_tag;
  logic                  hit;

  assign req_idx  = bus.IC_addr[INDEX_BITS+1:2];
  assign req_tag  = bus.IC_addr[31:INDEX_BITS+2];
  // The outstanding miss address doubles as the latched index and tag.
  assign miss_idx = mem_addr_q[INDEX_BITS+1:2];
  assign miss_tag = mem_addr_q[31:INDEX_BITS+2];
  assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    ins_sgn_d  = 1'b0;
    ins_d      = ins_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fill_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.IC_addr_sgn && !bus.rollback) begin
          if (hit) begin
            ins_sgn_d = 1'b1;
            ins_d     = data_mem[req_idx];
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = {bus.IC_addr[31:2], 2'b00};
            state_d    = MISS_WAIT;
          end
        end
      end
      MISS_WAIT: begin
        if (bus.mem_valid) begin
          fill_en   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (!bus.rollback) begin
            ins_sgn_d = 1'b1;
            ins_d     = bus.mem_data;
          end
        end else if (bus.rollback) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (bus.mem_valid) begin
          fill_en   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fill_en) valid_d[miss_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      ins_sgn_q  <= 1'b0;
      ins_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      ins_sgn_q  <= ins_sgn_d;
      ins_q      <= ins_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && fill_en) begin
      tag_mem[miss_idx]  <= miss_tag;
      data_mem[miss_idx] <= bus.mem_data;
    end
  end

  assign bus.IC_ins_sgn = ins_sgn_q;
  assign bus.IC_ins     = ins_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// tb_icache -- self-checking bench for icache. The bench plays both the
// instruction fetch unit and the memory controller. Its reference model is a
// per-slot record of which word address is resident and what word it holds.
module tb_icache;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;

  icache_if bus();

  icache #(.INDEX_BITS(6)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Reference model: slot -> resident word address and its data.
  bit          m_ok   [64];
  logic [29:0] m_wa   [64];
  logic [31:0] m_data [64];
  logic [31:0] exp_ins;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_ok[i] = 1'b0;
  endtask

  // rb_mode: 0 none, 1 rollback with request, 2 rollback in first wait
  // cycle, 3 rollback together with mem_valid.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] fill_data,
                       input int wait_cyc, input int rb_mode, input int rdy_off);
    int          idx;
    logic [29:0] wa;
    bit          hit;
    bit          quiet;
    idx  = int'(addr[7:2]);
    wa   = addr[31:2];
    hit  = m_ok[idx] && (m_wa[idx] == wa);
    bus.IC_addr_sgn = 1'b1;
    bus.IC_addr     = addr;
    bus.rollback    = (rb_mode == 1);
    tick();
    bus.IC_addr_sgn = 1'b0;
    bus.rollback    = 1'b0;
    bus.IC_addr     = $urandom;
    if (rb_mode == 1) begin
      check("rb_req_sgn", {31'd0, bus.IC_ins_sgn}, 32'd0);
      check("rb_req_memreq", {31'd0, bus.mem_req}, 32'd0);
      check("rb_req_ins_hold", bus.IC_ins, exp_ins);
      $display("fetch addr=%h rollback-with-request: no response", addr);
      return;
    end
    if (hit) begin
      check("hit_sgn", {31'd0, bus.IC_ins_sgn}, 32'd1);
      check("hit_ins", bus.IC_ins, m_data[idx]);
      check("hit_memreq", {31'd0, bus.mem_req}, 32'd0);
      exp_ins = m_data[idx];
      if (rdy_off > 0) begin
        rdy = 1'b0;
        for (int i = 0; i < rdy_off; i++) begin
          tick();
          check("hit_sgn_held", {31'd0, bus.IC_ins_sgn}, 32'd1);
        end
        rdy = 1'b1;
      end
      tick();
      check("hit_pulse_end", {31'd0, bus.IC_ins_sgn}, 32'd0);
      check("hit_ins_hold", bus.IC_ins, exp_ins);
      $display("fetch addr=%h hit ins=%h", addr, exp_ins);
      return;
    end
    check("miss_memreq", {31'd0, bus.mem_req}, 32'd1);
    check("miss_memaddr", bus.mem_addr, {wa, 2'b00});
    check("miss_sgn", {31'd0, bus.IC_ins_sgn}, 32'd0);
    quiet = 1'b0;
    for (int i = 0; i < wait_cyc; i++) begin
      bus.rollback    = (rb_mode == 2 && i == 0);
      bus.IC_addr_sgn = 1'($urandom_range(0, 1));
      tick();
      if (bus.rollback) quiet = 1'b1;
      bus.rollback    = 1'b0;
      bus.IC_addr_sgn = 1'b0;
      check("wait_memreq", {31'd0, bus.mem_req}, 32'd1);
      check("wait_memaddr", bus.mem_addr, {wa, 2'b00});
      check("wait_sgn", {31'd0, bus.IC_ins_sgn}, 32'd0);
    end
    if (rdy_off > 0) begin
      rdy = 1'b0;
      for (int i = 0; i < rdy_off; i++) begin
        bus.IC_addr_sgn = 1'b1;
        tick();
        check("rdy_memreq", {31'd0, bus.mem_req}, 32'd1);
        check("rdy_memaddr", bus.mem_addr, {wa, 2'b00});
        check("rdy_sgn", {31'd0, bus.IC_ins_sgn}, 32'd0);
      end
      bus.IC_addr_sgn = 1'b0;
      rdy = 1'b1;
    end
    bus.mem_valid = 1'b1;
    bus.mem_data  = fill_data;
    bus.rollback  = (rb_mode == 3);
    if (rb_mode == 3) quiet = 1'b1;
    tick();
    bus.mem_valid = 1'b0;
    bus.rollback  = 1'b0;
    bus.mem_data  = $urandom;
    m_ok[idx]   = 1'b1;
    m_wa[idx]   = wa;
    m_data[idx] = fill_data;
    check("fill_memreq", {31'd0, bus.mem_req}, 32'd0);
    if (quiet) begin
      check("fill_quiet_sgn", {31'd0, bus.IC_ins_sgn}, 32'd0);
      check("fill_quiet_ins", bus.IC_ins, exp_ins);
    end else begin
      check("fill_sgn", {31'd0, bus.IC_ins_sgn}, 32'd1);
      check("fill_ins", bus.IC_ins, fill_data);
      exp_ins = fill_data;
    end
    tick();
    check("fill_pulse_end", {31'd0, bus.IC_ins_sgn}, 32'd0);
    $display("fetch addr=%h miss fill=%h quiet=%0d ins=%h", addr, fill_data, quiet, bus.IC_ins);
  endtask

  initial begin
    logic [31:0] a;
    int          mode;
    bus.IC_addr_sgn = 1'b0;
    bus.IC_addr     = '0;
    bus.rollback    = 1'b0;
    bus.mem_valid   = 1'b0;
    bus.mem_data    = '0;
    model_clear();
    exp_ins = '0;

    // Reset state
    #12;
    check("rst_sgn", {31'd0, bus.IC_ins_sgn}, 32'd0);
    check("rst_ins", bus.IC_ins, 32'd0);
    check("rst_memreq", {31'd0, bus.mem_req}, 32'd0);
    check("rst_memaddr", bus.mem_addr, 32'd0);
    rst = 1'b1;
    tick();

    // Cold miss, hit, conflict, rollback mid-miss, rdy gating
    fetch(32'h0000_0000, 32'h0000_0093, 2, 0, 0);
    fetch(32'h0000_0000, 32'h0, 0, 0, 0);
    fetch(32'h0000_0100, 32'hDEAD_BEEF, 1, 0, 0);
    fetch(32'h0000_0000, 32'h0000_0093, 1, 0, 0);
    fetch(32'h0000_0040, 32'h1234_5678, 3, 2, 0);
    fetch(32'h0000_0040, 32'h0, 0, 0, 0);
    check("rollback_fill_kept", exp_ins, 32'h1234_5678);
    fetch(32'h0000_0080, 32'hCAFE_F00D, 1, 0, 4);
    fetch(32'h0000_0080, 32'h0, 0, 0, 2);

    // Asynchronous reset in the middle of a miss
    bus.IC_addr_sgn = 1'b1;
    bus.IC_addr     = 32'h0000_0200;
    tick();
    bus.IC_addr_sgn = 1'b0;
    check("pre_rst_memreq", {31'd0, bus.mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_memreq", {31'd0, bus.mem_req}, 32'd0);
    check("async_rst_memaddr", bus.mem_addr, 32'd0);
    check("async_rst_ins", bus.IC_ins, 32'd0);
    #2 rst = 1'b1;
    model_clear();
    exp_ins = '0;
    bus.mem_valid = 1'b1;
    bus.mem_data  = 32'h5555_AAAA;
    tick();
    bus.mem_valid = 1'b0;
    check("stray_valid_sgn", {31'd0, bus.IC_ins_sgn}, 32'd0);
    check("stray_valid_memreq", {31'd0, bus.mem_req}, 32'd0);
    fetch(32'h0000_0000, 32'h0000_0093, 1, 0, 0);
    $display("reset mid-miss: previously cached 0x0 refetched from memory");

    // Randomized traffic over a few slots and tags to force conflicts
    for (int n = 0; n < 150; n++) begin
      a = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 2)
          | 32'($urandom_range(0, 3));
      mode = $urandom_range(0, 9);
      if (mode > 3) mode = 0;
      fetch(a, $urandom, $urandom_range(0, 3), mode,
            ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
